// File: rtl/ascon_round_scheduler.sv
// ascon_round_scheduler: sequencing controller for the bit-serial ASCON
// permutation datapath. Each round runs one S-box phase and then five
// linear-diffusion phases (one per state word). Every phase is WORD_BITS
// clocks long, and one bit is processed per clock, LSB first.
// Optional feature macro: ASCON_SCHED_HALT_EN adds a 'halt' input that
// freezes the sequence without losing its position.
module ascon_round_scheduler #(
  parameter int WORD_BITS  = 64,
  parameter int MAX_ROUNDS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       short_perm,
`ifdef ASCON_SCHED_HALT_EN
  input  logic       halt,
`endif
  output logic       busy,
  output logic       done,
  output logic [4:0] enable,
  output logic [1:0] state_sel,
  output logic [2:0] temp_sel,
  output logic       temp_enable,
  output logic       constant,
  output logic [5:0] bit_idx,
  output logic [3:0] round_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SBOX = 2'd1;
  localparam logic [1:0] S_LIN  = 2'd2;

  localparam logic [5:0] LAST_BIT    = 6'(WORD_BITS - 1);
  localparam logic [2:0] LAST_WORD   = 3'd4;
  localparam logic [3:0] LAST_RND    = 4'd11;
  localparam logic [3:0] FIRST_RND_A = 4'(12 - MAX_ROUNDS);
  localparam logic [3:0] FIRST_RND_B = 4'd6;

  // Temp-mux word select code for linear-layer word w.
  function automatic logic [2:0] temp_code(input logic [2:0] w);
    logic [2:0] code;
    case (w)
      3'd0:    code = 3'b001;
      3'd1:    code = 3'b011;
      3'd2:    code = 3'b010;
      3'd3:    code = 3'b111;
      3'd4:    code = 3'b101;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  // Serial round-constant bit: c_r = {15-r, r} = {~r, r}. Only the low byte is non-zero.
  function automatic logic rc_bit(input logic [3:0] rnd, input logic [5:0] b);
    logic [7:0] c;
    c = {~rnd, rnd};
    return (b[5:3] == 3'b000) ? c[b[2:0]] : 1'b0;
  endfunction

  logic [1:0] r_state;
  logic [2:0] r_word;
  logic [5:0] r_bit;
  logic [3:0] r_round;
  logic       r_busy;
  logic       r_done;
  logic [4:0] r_enable;
  logic [1:0] r_state_sel;
  logic [2:0] r_temp_sel;
  logic       r_temp_enable;
  logic       r_constant;

  logic [1:0] w_nstate;
  logic [2:0] w_nword;
  logic [5:0] w_nbit;
  logic [3:0] w_nround;
  logic       w_done;
  logic       w_last_bit;
  logic       w_halt;

  logic       w_busy;
  logic [4:0] w_enable;
  logic [1:0] w_state_sel;
  logic [2:0] w_temp_sel;
  logic       w_temp_enable;
  logic       w_constant;

`ifdef ASCON_SCHED_HALT_EN
  assign w_halt = halt;
`else
  assign w_halt = 1'b0;
`endif

  assign w_last_bit = (r_bit == LAST_BIT);

  // Next-state logic: phase, word, bit and round counters.
  always_comb begin
    w_nstate = r_state;
    w_nword  = r_word;
    w_nbit   = r_bit;
    w_nround = r_round;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nstate = S_SBOX;
          w_nword  = 3'd0;
          w_nbit   = 6'd0;
          w_nround = short_perm ? FIRST_RND_B : FIRST_RND_A;
        end
      end
      S_SBOX: begin
        if (w_last_bit) begin
          w_nbit   = 6'd0;
          w_nword  = 3'd0;
          w_nstate = S_LIN;
        end else begin
          w_nbit = r_bit + 6'd1;
        end
      end
      S_LIN: begin
        if (w_last_bit) begin
          w_nbit = 6'd0;
          if (r_word == LAST_WORD) begin
            w_nword = 3'd0;
            if (r_round == LAST_RND) begin
              w_nstate = S_IDLE;
              w_done   = 1'b1;
            end else begin
              w_nround = r_round + 4'd1;
              w_nstate = S_SBOX;
            end
          end else begin
            w_nword = r_word + 3'd1;
          end
        end else begin
          w_nbit = r_bit + 6'd1;
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_nword  = 3'd0;
        w_nbit   = 6'd0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    w_busy        = 1'b0;
    w_enable      = 5'b00000;
    w_state_sel   = 2'b00;
    w_temp_sel    = 3'b000;
    w_temp_enable = 1'b0;
    w_constant    = 1'b0;
    case (w_nstate)
      S_SBOX: begin
        w_busy      = 1'b1;
        w_enable    = 5'b11111;
        w_state_sel = 2'b11;
        w_constant  = rc_bit(w_nround, w_nbit);
      end
      S_LIN: begin
        w_busy        = 1'b1;
        w_enable      = 5'b00001 << w_nword;
        w_state_sel   = 2'b10;
        w_temp_sel    = temp_code(w_nword);
        w_temp_enable = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // State and output registers. A halt freezes everything and gates the shift enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_word        <= 3'd0;
      r_bit         <= 6'd0;
      r_round       <= 4'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_enable      <= 5'b00000;
      r_state_sel   <= 2'b00;
      r_temp_sel    <= 3'b000;
      r_temp_enable <= 1'b0;
      r_constant    <= 1'b0;
    end else if (w_halt) begin
      r_enable      <= 5'b00000;
      r_temp_enable <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_nstate;
      r_word        <= w_nword;
      r_bit         <= w_nbit;
      r_round       <= w_nround;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_enable      <= w_enable;
      r_state_sel   <= w_state_sel;
      r_temp_sel    <= w_temp_sel;
      r_temp_enable <= w_temp_enable;
      r_constant    <= w_constant;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign enable      = r_enable;
  assign state_sel   = r_state_sel;
  assign temp_sel    = r_temp_sel;
  assign temp_enable = r_temp_enable;
  assign constant    = r_constant;
  assign bit_idx     = r_bit;
  assign round_idx   = r_round;

endmodule

// File: tb/tb_ascon_round_scheduler.sv
// Directed testbench for ascon_round_scheduler (WORD_BITS=64, MAX_ROUNDS=12).
// The halt scenario is compiled in only when ASCON_SCHED_HALT_EN is defined.
module tb_ascon_round_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       short_perm = 1'b0;
`ifdef ASCON_SCHED_HALT_EN
  logic       halt = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic [4:0] enable;
  logic [1:0] state_sel;
  logic [2:0] temp_sel;
  logic       temp_enable;
  logic       constant;
  logic [5:0] bit_idx;
  logic [3:0] round_idx;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ascon_round_scheduler #(.WORD_BITS(64), .MAX_ROUNDS(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .short_perm  (short_perm),
`ifdef ASCON_SCHED_HALT_EN
    .halt        (halt),
`endif
    .busy        (busy),
    .done        (done),
    .enable      (enable),
    .state_sel   (state_sel),
    .temp_sel    (temp_sel),
    .temp_enable (temp_enable),
    .constant    (constant),
    .bit_idx     (bit_idx),
    .round_idx   (round_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {done, busy, enable, state_sel, temp_sel, temp_enable, constant, bit_idx, round_idx}
  function automatic logic [23:0] outv();
    return {done, busy, enable, state_sel, temp_sel, temp_enable, constant, bit_idx, round_idx};
  endfunction

  // Called at the falling edge right after the start edge (cycle 0 of the run).
  task automatic run_perm(input string tag, input logic [3:0] r0, input int ncyc,
                          input logic [7:0] exp_c, input int poke_at,
                          input bit restart, input bit sp_next);
    int          k;
    int          got;
    int          bad;
    int          ph;
    int          b;
    logic [3:0]  r;
    logic [7:0]  rc;
    logic [7:0]  cbyte;
    logic [4:0]  e_en;
    logic [1:0]  e_ss;
    logic [2:0]  e_ts;
    logic        e_te;
    logic        e_c;
    logic [23:0] expv;
    logic [4:0]  len [5];
    logic [2:0]  lts [5];
    logic [2:0]  tcode [5];
    logic [4:0]  en_tab [5];
    tcode  = '{3'b001, 3'b011, 3'b010, 3'b111, 3'b101};
    en_tab = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    k = 0; got = -1; bad = 0; cbyte = 8'h00;
    for (int j = 0; j < 5; j++) begin
      len[j] = 5'b0;
      lts[j] = 3'b0;
    end
    while (k < ncyc + 64) begin
      if (done) begin
        got = k;
        break;
      end
      r  = 4'(int'(r0) + k / 384);
      ph = (k % 384) / 64;
      b  = k % 64;
      rc = {~r, r};
      if (ph == 0) begin
        e_en = 5'b11111; e_ss = 2'b11; e_ts = 3'b000; e_te = 1'b0;
        e_c  = (b < 8) ? rc[b] : 1'b0;
      end else begin
        e_en = en_tab[ph-1]; e_ss = 2'b10; e_ts = tcode[ph-1]; e_te = 1'b1;
        e_c  = 1'b0;
      end
      expv = {1'b0, 1'b1, e_en, e_ss, e_ts, e_te, e_c, 6'(b), r};
      if (k < ncyc && outv() !== expv) bad++;
      if (k < 8) cbyte[k] = constant;
      if (k >= 64 && k < 384 && (k % 64) == 0) begin
        len[k/64-1] = enable;
        lts[k/64-1] = temp_sel;
      end
      start = (k == poke_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, got, ncyc);
    chk({tag, "_seq_errs"}, bad, 0);
    chk({tag, "_const_byte"}, cbyte, exp_c);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("%s_lin_en%0d", tag, j), len[j], en_tab[j]);
      chk($sformatf("%s_lin_ts%0d", tag, j), lts[j], tcode[j]);
    end
    chk({tag, "_done_outs"}, outv(), {1'b1, 1'b0, 5'b0, 2'b0, 3'b0, 1'b0, 1'b0, 6'd0, 4'd11});
    if (restart) begin
      start = 1'b1;
      short_perm = sp_next;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_restart_busy"}, busy, 1'b1);
      chk({tag, "_restart_round"}, round_idx, sp_next ? 4'd6 : 4'd0);
      chk({tag, "_restart_done_low"}, done, 1'b0);
    end else begin
      @(negedge clk);
      chk({tag, "_done_pulse_end"}, {done, busy}, 2'b00);
    end
  endtask

  initial begin
    int hk;
    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outv(), 24'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", outv(), 24'h0);

    // Reset in the middle of a permutation
    start = 1'b1; short_perm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_reset_outs", outv(), 24'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", outv(), 24'h0);

    // Full permutation p^a after reset
    start = 1'b1; short_perm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    run_perm("pa", 4'd0, 4608, 8'hF0, -1, 1'b0, 1'b0);

    // p^a with an ignored start while busy, then a restart (p^b) in the done cycle
    start = 1'b1; short_perm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    run_perm("pa_poke", 4'd0, 4608, 8'hF0, 1000, 1'b1, 1'b1);
    run_perm("pb", 4'd6, 2304, 8'h96, -1, 1'b0, 1'b0);

`ifdef ASCON_SCHED_HALT_EN
    // Halt for 10 cycles at bit 30 of round 3
    start = 1'b1; short_perm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    hk = 0;
    repeat (1182) begin
      @(negedge clk);
      hk++;
    end
    chk("pre_halt_pos", {round_idx, bit_idx}, {4'd3, 6'd30});
    halt = 1'b1;
    @(negedge clk);
    hk++;
    chk("halt_frozen", {busy, enable, state_sel, temp_enable, bit_idx, round_idx},
        {1'b1, 5'b0, 2'b11, 1'b0, 6'd30, 4'd3});
    repeat (9) begin
      @(negedge clk);
      hk++;
    end
    chk("halt_still", {enable, bit_idx}, {5'b0, 6'd30});
    halt = 1'b0;
    @(negedge clk);
    hk++;
    chk("halt_resume", {enable, bit_idx}, {5'b11111, 6'd31});
    while (!done && hk < 6000) begin
      @(negedge clk);
      hk++;
    end
    chk("halt_latency", hk, 4618);
`else
    hk = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
